// File: rtl/read_module_if.sv
// Request/memory/result bundle for the vector-datapath read sequencer.
// The master side issues requests and models the data memory; the slave side is read_module.
interface read_module_if #(
  parameter int unsigned VEC_LEN = 20,
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned ADDR_W  = 6
);
  logic                              start;
  logic                              op_type;
  logic [ADDR_W-1:0]                 base_address;
  logic                              read_en;
  logic [ADDR_W-1:0]                 read_address;
  logic [DATA_W-1:0]                 read_data;
  logic [DATA_W-1:0]                 scalar_data;
  logic [VEC_LEN-1:0][DATA_W-1:0]    vector_data;
  logic                              busy;
  logic                              done;

  modport master (
    output start, op_type, base_address, read_data,
    input  read_en, read_address, scalar_data, vector_data, busy, done
  );

  modport slave (
    input  start, op_type, base_address, read_data,
    output read_en, read_address, scalar_data, vector_data, busy, done
  );
endinterface

// File: rtl/read_module.sv
// Memory-read sequencer: issues one scalar or VEC_LEN consecutive reads from a base address
// and assembles the returned words into scalar/vector result registers with a done pulse.
module read_module #(
  parameter int unsigned VEC_LEN = 20,
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned MEM_LAT = 1
) (
  input logic         clk,
  input logic         rst,
  read_module_if.slave bus
);
  localparam int unsigned IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                      state;
  logic                            op_q;
  logic [IDX_W-1:0]                issue_idx;
  logic [IDX_W-1:0]                last_idx;

  // Return pipeline: one entry per issued read, aligned with the memory latency.
  logic [MEM_LAT-1:0]              pipe_v;
  logic [MEM_LAT-1:0]              pipe_last;
  logic [MEM_LAT-1:0][IDX_W-1:0]   pipe_idx;

  logic                            cap_v;
  logic                            cap_last;
  logic [IDX_W-1:0]                cap_idx;

  assign cap_v    = pipe_v[MEM_LAT-1];
  assign cap_last = pipe_last[MEM_LAT-1];
  assign cap_idx  = pipe_idx[MEM_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      op_q             <= 1'b0;
      issue_idx        <= '0;
      last_idx         <= '0;
      pipe_v           <= '0;
      pipe_last        <= '0;
      pipe_idx         <= '0;
      bus.read_en      <= 1'b0;
      bus.read_address <= '0;
      bus.scalar_data  <= '0;
      bus.vector_data  <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      bus.done <= 1'b0;

      for (int unsigned i = MEM_LAT - 1; i > 0; i--) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
      end
      // The strobe held during this cycle becomes a pipeline entry at its closing edge.
      pipe_v[0]    <= bus.read_en;
      pipe_last[0] <= (issue_idx == last_idx);
      pipe_idx[0]  <= issue_idx;

      if (cap_v) begin
        if (op_q) begin
          bus.vector_data[cap_idx] <= bus.read_data;
        end else begin
          bus.scalar_data <= bus.read_data;
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q             <= bus.op_type;
            bus.read_address <= bus.base_address;
            issue_idx        <= '0;
            last_idx         <= bus.op_type ? IDX_W'(VEC_LEN - 1) : '0;
            bus.read_en      <= 1'b1;
            bus.busy         <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_idx == last_idx) begin
            bus.read_en <= 1'b0;
            state       <= DRAIN;
          end else begin
            issue_idx        <= issue_idx + 1'b1;
            bus.read_address <= bus.read_address + 1'b1;
          end
        end
        DRAIN: begin
        end
        default: state <= IDLE;
      endcase

      // Completion is keyed off the last capture, so it wins over any state transition.
      if (cap_v && cap_last) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_read_module.sv
// Directed bench for read_module: memory returns mem[a]=a+16; MEM_LAT=1 and MEM_LAT=3 instances.
module tb_read_module;
  localparam int unsigned VL = 20;
  localparam int unsigned DW = 10;
  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  logic rst;
  logic start1, start3, op_type;
  logic [AW-1:0] base_address;

  always #5 clk = ~clk;

  read_module_if #(.VEC_LEN(VL), .DATA_W(DW), .ADDR_W(AW)) bus1 ();
  read_module_if #(.VEC_LEN(VL), .DATA_W(DW), .ADDR_W(AW)) bus3 ();

  assign bus1.start        = start1;
  assign bus1.op_type      = op_type;
  assign bus1.base_address = base_address;
  assign bus3.start        = start3;
  assign bus3.op_type      = op_type;
  assign bus3.base_address = base_address;

  read_module #(.VEC_LEN(VL), .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  read_module #(.VEC_LEN(VL), .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return DW'(a) + DW'(16);
  endfunction

  // Synchronous memories; all-ones is driven when no read is in flight.
  logic [DW-1:0] m1;
  logic [DW-1:0] m3 [3];
  always @(posedge clk) begin
    m1    <= bus1.read_en ? mem_val(bus1.read_address) : '1;
    m3[0] <= bus3.read_en ? mem_val(bus3.read_address) : '1;
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign bus1.read_data = m1;
  assign bus3.read_data = m3[2];

  int n_cmp = 0;
  int n_err = 0;

  logic [VL-1:0][DW-1:0] exp_vec;
  logic [DW-1:0]         exp_scalar;

  typedef struct {
    logic          op;
    logic [AW-1:0] base;
    int            lat;
    logic [DW-1:0] scal;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs from the negedge after the start edge until done (bounded), tracking the issue stream.
  task automatic track(input logic [AW-1:0] base, input int pulse_at, output int edges,
                       output int issues, output bit addr_ok, output bit busy_ok);
    edges = 0; issues = 0; addr_ok = 1'b1; busy_ok = 1'b1;
    while (bus1.done !== 1'b1 && edges < 100) begin
      if (bus1.read_en === 1'b1) begin
        if (bus1.read_address !== AW'(int'(base) + issues)) addr_ok = 1'b0;
        issues++;
      end
      if (bus1.busy !== 1'b1) busy_ok = 1'b0;
      if (edges == pulse_at) begin
        start1 = 1'b1; op_type = 1'b0; base_address = '0;
      end else begin
        start1 = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start1 = 1'b0;
  endtask

  task automatic run_op(input logic op, input logic [AW-1:0] base, input int lat,
                        input logic [DW-1:0] scal, input string tag);
    int edges, issues;
    bit a_ok, b_ok;
    int n;
    n = op ? int'(VL) : 1;
    op_type = op; base_address = base; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    track(base, -1, edges, issues, a_ok, b_ok);
    if (op) for (int i = 0; i < int'(VL); i++) exp_vec[i] = mem_val(AW'(int'(base) + i));
    exp_scalar = scal;
    check({tag, ".latency"}, 256'(edges), 256'(lat));
    check({tag, ".issues"}, 256'(issues), 256'(n));
    check({tag, ".addr_seq"}, 256'(a_ok), 256'(1));
    check({tag, ".busy_held"}, 256'(b_ok), 256'(1));
    check({tag, ".done"}, 256'(bus1.done), 256'(1));
    check({tag, ".busy_low"}, 256'(bus1.busy), 256'(0));
    check({tag, ".scalar"}, 256'(bus1.scalar_data), 256'(exp_scalar));
    check({tag, ".vector"}, 256'(bus1.vector_data), 256'(exp_vec));
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 256'(bus1.done), 256'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, issues, dones;
    bit a_ok, b_ok;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; op_type = 1'b0; base_address = '0;
    exp_vec = '0; exp_scalar = '0;
    tbl[0] = '{op: 1'b0, base: 6'd34, lat: 2,  scal: 10'd50};
    tbl[1] = '{op: 1'b1, base: 6'd34, lat: 21, scal: 10'd50};
    tbl[2] = '{op: 1'b1, base: 6'd60, lat: 21, scal: 10'd50};
    tbl[3] = '{op: 1'b0, base: 6'd63, lat: 2,  scal: 10'd79};
    tbl[4] = '{op: 1'b0, base: 6'd0,  lat: 2,  scal: 10'd16};

    repeat (3) @(negedge clk);
    check("reset.read_en", 256'(bus1.read_en), 256'(0));
    check("reset.read_address", 256'(bus1.read_address), 256'(0));
    check("reset.busy", 256'(bus1.busy), 256'(0));
    check("reset.done", 256'(bus1.done), 256'(0));
    check("reset.scalar", 256'(bus1.scalar_data), 256'(0));
    check("reset.vector", 256'(bus1.vector_data), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].op, tbl[i].base, tbl[i].lat, tbl[i].scal, $sformatf("vec%0d", i));
      if (i == 2) begin
        check("wrap.elem4", 256'(bus1.vector_data[4]), 256'(16));
        check("wrap.elem19", 256'(bus1.vector_data[19]), 256'(31));
      end
    end

    // Reset in the middle of a vector read, sampled at E5.
    op_type = 1'b1; base_address = 6'd34; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort.read_en", 256'(bus1.read_en), 256'(0));
    check("abort.busy", 256'(bus1.busy), 256'(0));
    check("abort.done", 256'(bus1.done), 256'(0));
    check("abort.read_address", 256'(bus1.read_address), 256'(0));
    check("abort.scalar", 256'(bus1.scalar_data), 256'(0));
    check("abort.vector", 256'(bus1.vector_data), 256'(0));
    rst = 1'b0;
    exp_vec = '0; exp_scalar = '0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus1.done === 1'b1) dones++;
    end
    check("abort.no_done", 256'(dones), 256'(0));
    check("abort.vector_quiet", 256'(bus1.vector_data), 256'(0));
    run_op(1'b0, 6'd10, 2, 10'd26, "post_reset");

    // Start while busy is dropped; start in the done cycle is accepted.
    op_type = 1'b1; base_address = 6'd34; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    track(6'd34, 5, edges, issues, a_ok, b_ok);
    for (int i = 0; i < int'(VL); i++) exp_vec[i] = DW'(50 + i);
    check("busy_start.latency", 256'(edges), 256'(21));
    check("busy_start.issues", 256'(issues), 256'(20));
    check("busy_start.addr_seq", 256'(a_ok), 256'(1));
    check("busy_start.done", 256'(bus1.done), 256'(1));
    check("busy_start.scalar", 256'(bus1.scalar_data), 256'(26));
    check("busy_start.vector", 256'(bus1.vector_data), 256'(exp_vec));
    op_type = 1'b0; base_address = 6'd1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    track(6'd1, -1, edges, issues, a_ok, b_ok);
    check("b2b.latency", 256'(edges), 256'(2));
    check("b2b.scalar", 256'(bus1.scalar_data), 256'(17));
    check("b2b.vector", 256'(bus1.vector_data), 256'(exp_vec));
    @(negedge clk);
    check("b2b.done_one_cycle", 256'(bus1.done), 256'(0));

    // MEM_LAT=3 vector read.
    op_type = 1'b1; base_address = 6'd34; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    edges = 0;
    while (bus3.done !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("lat3.latency", 256'(edges), 256'(23));
    check("lat3.vector", 256'(bus3.vector_data), 256'(exp_vec));
    check("lat3.scalar", 256'(bus3.scalar_data), 256'(0));
    @(negedge clk);
    check("lat3.done_one_cycle", 256'(bus3.done), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
